// File: rtl/lcd_mem_arb_if.sv
// Shared memory-bus bundle between blink decode, the LCD fetcher and the arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface lcd_mem_arb_if;
  logic [21:0] cpu_ma;
  logic        cpu_mrq_n;
  logic        cpu_rd_n;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic        lcd_gnt;
  logic        lcd_vld;
  logic [7:0]  lcd_data;
  logic [21:0] mem_a;
  logic        mem_oe_n;
  logic [7:0]  mem_din;
  logic        lcd_own;
  logic        cpu_stall;

  modport slave (
    input  cpu_ma, cpu_mrq_n, cpu_rd_n, lcd_req, lcd_addr, mem_din,
    output lcd_gnt, lcd_vld, lcd_data, mem_a, mem_oe_n, lcd_own, cpu_stall
  );

  modport master (
    output cpu_ma, cpu_mrq_n, cpu_rd_n, lcd_req, lcd_addr, mem_din,
    input  lcd_gnt, lcd_vld, lcd_data, mem_a, mem_oe_n, lcd_own, cpu_stall
  );
endinterface

// File: rtl/lcd_mem_arb.sv
// Memory bus arbiter: the Z80 always wins, the LCD fetcher borrows cycles where MREQ is idle,
// and a starved fetch asks blink to stall the Z80 clock until the byte is delivered.
module lcd_mem_arb #(
  parameter int ACC_CYC = 2,
  parameter int STARVE  = 16
) (
  input  logic          mck,
  input  logic          rin_n,
  lcd_mem_arb_if.slave  bus
);

  localparam int             CW       = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0]  ACC_LOAD = CW'(ACC_CYC - 1);
  localparam logic [4:0]     WAIT_MAX = 5'd31;

  typedef enum logic [1:0] {IDLE, PENDING, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [21:0]   addr, addr_nxt;
  logic [CW-1:0] acc_cnt, acc_nxt;
  logic [4:0]    wait_cnt, wait_nxt;
  logic [7:0]    data_buf, buf_nxt;
  logic [7:0]    data;
  logic          gnt, gnt_nxt;
  logic          vld;
  logic          vld_pend, pend_nxt;
  logic          stall, stall_nxt;
  logic          wait_inc;

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      state    <= IDLE;
      addr     <= '0;
      acc_cnt  <= '0;
      wait_cnt <= '0;
      data_buf <= 8'h00;
      data     <= 8'h00;
      gnt      <= 1'b0;
      vld      <= 1'b0;
      vld_pend <= 1'b0;
      stall    <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      acc_cnt  <= acc_nxt;
      wait_cnt <= wait_nxt;
      data_buf <= buf_nxt;
      gnt      <= gnt_nxt;
      vld_pend <= pend_nxt;
      vld      <= vld_pend;
      stall    <= stall_nxt;
      if (vld_pend) data <= data_buf;
    end
  end

  // The sampled byte waits one cycle in data_buf so lcd_data only changes with lcd_vld;
  // no new request is taken while that delivery is still pending.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    acc_nxt   = acc_cnt;
    gnt_nxt   = 1'b0;
    pend_nxt  = 1'b0;
    buf_nxt   = data_buf;
    wait_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lcd_req && !vld_pend) begin
          addr_nxt = bus.lcd_addr;
          gnt_nxt  = 1'b1;
          if (bus.cpu_mrq_n) begin
            state_nxt = ACCESS;
            acc_nxt   = ACC_LOAD;
          end else begin
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        wait_inc = 1'b1;
        if (bus.cpu_mrq_n) begin
          state_nxt = ACCESS;
          acc_nxt   = ACC_LOAD;
        end
      end
      ACCESS: begin
        if (!bus.cpu_mrq_n) begin
          state_nxt = PENDING;
          wait_inc  = 1'b1;
        end else if (acc_cnt == '0) begin
          buf_nxt   = bus.mem_din;
          pend_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          acc_nxt = acc_cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    wait_nxt = wait_cnt;
    if (vld_pend)
      wait_nxt = '0;
    else if (wait_inc && wait_cnt != WAIT_MAX)
      wait_nxt = wait_cnt + 5'd1;

    stall_nxt = vld_pend ? 1'b0 : (stall | (32'(wait_nxt) >= STARVE));
  end

  // CPU MREQ takes the bus in the same cycle it appears, even mid-access.
  always_comb begin
    bus.mem_a    = bus.cpu_ma;
    bus.mem_oe_n = 1'b1;
    bus.lcd_own  = 1'b0;
    if (!bus.cpu_mrq_n) begin
      bus.mem_oe_n = bus.cpu_rd_n;
    end else if (state == ACCESS) begin
      bus.mem_a    = addr;
      bus.mem_oe_n = 1'b0;
      bus.lcd_own  = 1'b1;
    end
  end

  assign bus.lcd_gnt   = gnt;
  assign bus.lcd_vld   = vld;
  assign bus.lcd_data  = data;
  assign bus.cpu_stall = stall;

endmodule
